// File: rtl/addsub_bist_driver_if.sv
// rtl/addsub_bist_driver_if.sv - stimulus/response bus between the BIST driver and the adder under test
interface addsub_bist_driver_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_sel;
  logic [WIDTH-1:0] dut_sum_diff;
  logic             dut_cbo;

  modport master (output dut_a, dut_b, dut_sel, input dut_sum_diff, dut_cbo);
  modport slave  (input dut_a, dut_b, dut_sel, output dut_sum_diff, dut_cbo);
endinterface

// File: rtl/addsub_bist_driver.sv
// rtl/addsub_bist_driver.sv - exhaustive sweep driver and golden-model checker for the adder_subtractor
module addsub_bist_driver #(
  parameter int WIDTH             = 4,
  parameter int SETTLE_CYCLES     = 1,
  parameter bit CBO_SUB_IS_BORROW = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic                 first_fail_valid,
  output logic [WIDTH-1:0]     first_fail_a,
  output logic [WIDTH-1:0]     first_fail_b,
  output logic                 first_fail_sel,
  addsub_bist_driver_if.master bus
);
  localparam int IW = 2*WIDTH+1;
  localparam int EW = 2*WIDTH+2;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t           state, state_next;
  logic [IW-1:0]    idx;
  logic [3:0]       settle_cnt;
  logic [WIDTH-1:0] cur_a, cur_b;
  logic             cur_sel;
  logic [WIDTH-1:0] exp_sum;
  logic             exp_cbo;
  logic             start_ok, last_vec, settle_end, mismatch;

  // The applied vector is the index itself, so dut_* are register outputs.
  assign cur_sel     = idx[IW-1];
  assign cur_a       = idx[2*WIDTH-1:WIDTH];
  assign cur_b       = idx[WIDTH-1:0];
  assign bus.dut_a   = cur_a;
  assign bus.dut_b   = cur_b;
  assign bus.dut_sel = cur_sel;

  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign last_vec   = (idx == {IW{1'b1}});
  assign settle_end = (settle_cnt == SETTLE_LAST);

  always_comb begin
    exp_sum = '0;
    exp_cbo = 1'b0;
    if (cur_sel) begin
      {exp_cbo, exp_sum} = {1'b0, cur_a} + {1'b0, cur_b};
    end else begin
      exp_sum = cur_a - cur_b;
      exp_cbo = CBO_SUB_IS_BORROW ? (cur_a < cur_b) : (cur_a >= cur_b);
    end
  end

  assign mismatch = (state == CHECK) &&
                    ((bus.dut_sum_diff != exp_sum) || (bus.dut_cbo != exp_cbo));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = (SETTLE_CYCLES > 0) ? APPLY : CHECK;
      APPLY:      if (settle_end) state_next = CHECK;
      CHECK: begin
        if (last_vec)               state_next = DONE;
        else if (SETTLE_CYCLES > 0) state_next = APPLY;
        else                        state_next = CHECK;
      end
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == APPLY) || (state == CHECK);
    done = (state == DONE);
    pass = (state == DONE) && (err_count == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx              <= '0;
      settle_cnt       <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_a     <= '0;
      first_fail_b     <= '0;
      first_fail_sel   <= 1'b0;
    end else if (start_ok) begin
      idx              <= '0;
      settle_cnt       <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_a     <= '0;
      first_fail_b     <= '0;
      first_fail_sel   <= 1'b0;
    end else begin
      if (state == APPLY) begin
        settle_cnt <= settle_end ? 4'd0 : settle_cnt + 4'd1;
      end
      if (state == CHECK) begin
        // Hold the last vector on the final check; idx never wraps.
        if (!last_vec) idx <= idx + IW'(1);
        if (mismatch) begin
          if (err_count != {EW{1'b1}}) err_count <= err_count + EW'(1);
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_a     <= cur_a;
            first_fail_b     <= cur_b;
            first_fail_sel   <= cur_sel;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_addsub_bist_driver.sv
// tb/tb_addsub_bist_driver.sv - scoreboard bench for addsub_bist_driver with a fault-injectable adder model
module tb_addsub_bist_driver;
  localparam int W  = 4;
  localparam int NV = 512;

  typedef struct {
    int errs;
    int ffv;
    int ffa;
    int ffb;
    int ffs;
    int lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_v[2];
  logic       busy_v[2], done_v[2], pass_v[2], ffv_v[2], ffs_v[2];
  logic [9:0] err_v[2];
  logic [3:0] ffa_v[2], ffb_v[2];
  logic [8:0] vec_v[2];

  int   fmode[2], fbit[2], fidx[2];
  exp_t q0[$], q1[$];
  int   n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  addsub_bist_driver_if #(.WIDTH(W)) bus0();
  addsub_bist_driver_if #(.WIDTH(W)) bus1();

  addsub_bist_driver #(.WIDTH(W), .SETTLE_CYCLES(1), .CBO_SUB_IS_BORROW(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_count(err_v[0]), .first_fail_valid(ffv_v[0]),
    .first_fail_a(ffa_v[0]), .first_fail_b(ffb_v[0]), .first_fail_sel(ffs_v[0]), .bus(bus0.master)
  );

  addsub_bist_driver #(.WIDTH(W), .SETTLE_CYCLES(0), .CBO_SUB_IS_BORROW(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_count(err_v[1]), .first_fail_valid(ffv_v[1]),
    .first_fail_a(ffa_v[1]), .first_fail_b(ffb_v[1]), .first_fail_sel(ffs_v[1]), .bus(bus1.master)
  );

  function automatic int settle_of(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  // Arithmetic definition of a correct adder_subtractor; vector v = {sel, a, b}.
  function automatic logic [4:0] golden(int v, bit borrow);
    int a, b;
    a = (v >> 4) & 15;
    b = v & 15;
    if (v >= 256) return 5'(a + b);
    return {(borrow ? (a < b) : (a >= b)), 4'(a - b)};
  endfunction

  function automatic logic [4:0] faulty(int v, int mode, int fb, int fi, bit borrow);
    logic [4:0] r;
    r = golden(v, borrow);
    case (mode)
      1: r[fb] = 1'b0;
      2: if (v < 256) r[4] = ~r[4];
      3: if (v == fi) r[fb] = ~r[fb];
      default: ;
    endcase
    return r;
  endfunction

  assign {bus0.dut_cbo, bus0.dut_sum_diff} =
    faulty(int'({bus0.dut_sel, bus0.dut_a, bus0.dut_b}), fmode[0], fbit[0], fidx[0], 1'b1);
  assign {bus1.dut_cbo, bus1.dut_sum_diff} =
    faulty(int'({bus1.dut_sel, bus1.dut_a, bus1.dut_b}), fmode[1], fbit[1], fidx[1], 1'b0);
  assign vec_v[0] = {bus0.dut_sel, bus0.dut_a, bus0.dut_b};
  assign vec_v[1] = {bus1.dut_sel, bus1.dut_a, bus1.dut_b};

  function automatic exp_t model(int i, int mode, int fb, int fi);
    exp_t e;
    bit   borrow;
    borrow = (i == 0);
    e = '{errs: 0, ffv: 0, ffa: 0, ffb: 0, ffs: 0, lat: NV * (settle_of(i) + 1)};
    for (int v = 0; v < NV; v++) begin
      if (golden(v, borrow) != faulty(v, mode, fb, fi, borrow)) begin
        if (e.errs == 0) e = '{errs: 0, ffv: 1, ffa: (v >> 4) & 15, ffb: v & 15, ffs: v >> 8, lat: e.lat};
        e.errs++;
      end
    end
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: tracks busy cycles and the vector sequence, checks results when done rises.
  initial begin
    int   busy_cnt[2], seq_bad[2];
    logic done_q[2];
    exp_t e;
    for (int i = 0; i < 2; i++) begin busy_cnt[i] = 0; seq_bad[i] = 0; done_q[i] = 1'b0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          busy_cnt[i] = 0; seq_bad[i] = 0; done_q[i] = 1'b0;
        end else begin
          if (busy_v[i]) begin
            if (int'(vec_v[i]) != busy_cnt[i] / (settle_of(i) + 1)) seq_bad[i]++;
            busy_cnt[i]++;
          end
          if (done_v[i] && !done_q[i]) begin
            if (((i == 0) ? q0.size() : q1.size()) == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL u%0d.unexpected_done: got done=1, expected no completion", i);
            end else begin
              if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
              check($sformatf("u%0d.err_count", i), 32'(err_v[i]), e.errs);
              check($sformatf("u%0d.pass", i), 32'(pass_v[i]), 32'(e.errs == 0));
              check($sformatf("u%0d.first_fail_valid", i), 32'(ffv_v[i]), e.ffv);
              check($sformatf("u%0d.first_fail_a", i), 32'(ffa_v[i]), e.ffa);
              check($sformatf("u%0d.first_fail_b", i), 32'(ffb_v[i]), e.ffb);
              check($sformatf("u%0d.first_fail_sel", i), 32'(ffs_v[i]), e.ffs);
              check($sformatf("u%0d.busy_cycles", i), busy_cnt[i], e.lat);
              check($sformatf("u%0d.vector_order_errors", i), seq_bad[i], 0);
              check($sformatf("u%0d.last_vector", i), 32'(vec_v[i]), NV - 1);
            end
            busy_cnt[i] = 0; seq_bad[i] = 0;
          end
          done_q[i] = done_v[i];
        end
      end
    end
  end

  task automatic pulse_start(int i);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  task automatic run(int i, int mode, int fb, int fi, int poke);
    int n;
    @(negedge clk);
    fmode[i] = mode; fbit[i] = fb; fidx[i] = fi;
    if (i == 0) q0.push_back(model(i, mode, fb, fi)); else q1.push_back(model(i, mode, fb, fi));
    pulse_start(i);
    check($sformatf("u%0d.busy_after_start", i), 32'(busy_v[i]), 1);
    check($sformatf("u%0d.cleared_at_start", i), {ffv_v[i], done_v[i], pass_v[i], err_v[i]}, 0);
    n = 1;
    if (poke > 0) begin
      repeat (poke - 1) @(negedge clk);
      pulse_start(i);
      n = poke + 1;
    end
    while (!done_v[i] && n < NV * (settle_of(i) + 1) + 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("u%0d.done_within_budget", i), 32'(done_v[i]), 1);
  endtask

  function automatic logic [31:0] outs0();
    return {busy_v[0], done_v[0], pass_v[0], err_v[0], ffv_v[0], ffa_v[0], ffb_v[0], ffs_v[0], vec_v[0]};
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; fmode[i] = 0; fbit[i] = 0; fidx[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("u0.reset_outputs", outs0(), 0);
    check("u1.reset_outputs",
          {busy_v[1], done_v[1], pass_v[1], err_v[1], ffv_v[1], ffa_v[1], ffb_v[1], ffs_v[1], vec_v[1]}, 0);
    rst_n = 1'b1;

    run(0, 0, 0, 0, 0);
    run(0, 1, 0, 0, 0);
    run(0, 2, 0, 0, 0);
    run(0, 0, 0, 0, 0);
    run(1, 0, 0, 0, 0);
    run(1, 2, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      run(k % 2, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, NV - 1)), 0);
    end
    run(0, 0, 0, 0, 100);

    @(negedge clk);
    fmode[0] = 1;
    fbit[0] = 0;
    pulse_start(0);
    repeat (299) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("u0.outputs_on_midsweep_reset", outs0(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("u0.idle_after_reset", {busy_v[0], done_v[0], err_v[0]}, 0);
    run(0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/addsub_bist_driver.md
Name: addsub_bist_driver

Overview:
- Self-checking stimulus driver and response checker for the 4-bit adder_subtractor.
- Owns the other end of its port interface: drives a, b and sel_add1_sub0, samples sum_diff and carry_borrow_out, and compares them against an internal golden model.
- Sweeps all 2^(2*WIDTH+1) input combinations exhaustively, then reports pass/fail, the error count and the first failing vector.
- Used for on-chip/FPGA bring-up of the adder and as a reusable checker in simulation.

Parameters:
- WIDTH, 4: operand width; must match the DUT.
- SETTLE_CYCLES, 1: wait cycles after applying a vector before the response is checked. Legal range 0..15.
- CBO_SUB_IS_BORROW, 1: expected carry_borrow_out in subtract mode. 1 = borrow, i.e. (a<b). 0 = raw two's-complement carry, i.e. (a>=b).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run a full sweep; sampled only in IDLE or DONE.
- busy  out  1  high while the sweep is running.
- done  out  1  high from sweep completion until the next start.
- pass  out  1  valid while done=1; 1 iff err_count==0.
- err_count  out  2*WIDTH+2  number of mismatching vectors; saturating.
- first_fail_valid  out  1  a mismatch has been captured.
- first_fail_a  out  WIDTH  a of the first mismatching vector.
- first_fail_b  out  WIDTH  b of the first mismatching vector.
- first_fail_sel  out  1  sel of the first mismatching vector.
- dut_a  out  WIDTH  drives DUT a; registered.
- dut_b  out  WIDTH  drives DUT b; registered.
- dut_sel  out  1  drives DUT sel_add1_sub0 (1 = add, 0 = subtract); registered.
- dut_sum_diff  in  WIDTH  DUT result.
- dut_cbo  in  1  DUT carry_borrow_out.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, vector index idx=0, settle counter 0. Reset asserted mid-sweep aborts immediately. After release the block sits in IDLE and no results are retained.
- Vector index idx is 2*WIDTH+1 bits wide and maps as sel=idx[MSB], a=idx[2W-1:W], b=idx[W-1:0]. Ordering is therefore: all subtract vectors first (a major, b minor), then all add vectors.
- States: IDLE, APPLY, CHECK, DONE.
- IDLE/DONE with start=1:
  - Clear err_count, first_fail_*, done and pass.
  - Set idx=0 and drive dut_* = vector 0.
  - Go to APPLY if SETTLE_CYCLES>0, else CHECK.
  - busy=1 from the following cycle.
- APPLY: dut_* held stable. Stays exactly SETTLE_CYCLES cycles, then goes to CHECK.
- CHECK (one cycle): compares dut_sum_diff/dut_cbo combinationally against the expected values; results update at the closing edge.
  - On mismatch: err_count+1, saturating at all-ones.
  - On the first mismatch only: capture first_fail_a/b/sel and set first_fail_valid.
  - If idx is the last index: go to DONE; done=1, busy=0, pass=(final err_count==0); dut_* hold the last vector.
  - Otherwise: idx+1, dut_* = next vector, then APPLY, or CHECK again if SETTLE_CYCLES=0.
- Expected values:
  - Add: {cbo,sum} = a+b computed at WIDTH+1 bits.
  - Subtract: sum = (a-b) mod 2^WIDTH; cbo = (a<b) if CBO_SUB_IS_BORROW=1, else (a>=b).
- Timing: each vector takes SETTLE_CYCLES+1 cycles. done rises 2^(2W+1)*(SETTLE_CYCLES+1) cycles after the edge that samples start.
- Boundaries:
  - start while busy is ignored.
  - start in DONE restarts the sweep.
  - A mismatch on the last vector is counted before pass is computed.
  - idx never wraps during a run.

Test Plan:
- Correct DUT, SETTLE_CYCLES=1, one start pulse -> busy for 1024 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0.
- DUT wrapper with sum_diff[0] stuck at 0 -> err_count=256, pass=0, first fail a=0, b=1, sel=0 (0-1 = 15).
- DUT wrapper with cbo inverted in subtract mode only, CBO_SUB_IS_BORROW=1 -> err_count=256, first fail a=0, b=0, sel=0.
- SETTLE_CYCLES=0 with a correct DUT -> done exactly 512 cycles after start. dut_* change every cycle; last applied vector is a=15, b=15, sel=1.
- Second start pulse at sweep cycle 100 -> ignored, completion time unchanged. Then rst_n=0 at cycle 300 of a new sweep -> all outputs 0 immediately, state IDLE.
- Run with the stuck-at fault, then start again with a correct DUT -> err_count and first_fail_* cleared at the restart, final pass=1.
